// File: rtl/nios2_oci_dct_pkg.sv
// Shared types and widths for the Nios II OCI DCT trace sequencer.
package nios2_oci_dct_pkg;

  localparam int unsigned DCT_ATOM_W         = 10;
  localparam int unsigned DCT_ATOMS_PER_WORD = 3;
  localparam int unsigned DCT_WORD_W         = DCT_ATOM_W * DCT_ATOMS_PER_WORD;
  localparam int unsigned DCT_CNT_W          = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PACK,
    ST_WRITE,
    ST_FLUSH,
    ST_DONE
  } dct_state_e;

endpackage

// File: rtl/nios2_oci_dct_ctrl_if.sv
// Atom source handshake and trace-memory write port of the DCT sequencer.
interface nios2_oci_dct_ctrl_if
  import nios2_oci_dct_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
);

  logic                  atom_valid;
  logic [DCT_ATOM_W-1:0] atom_data;
  logic                  atom_ready;
  logic                  tm_wr_req;
  logic [ADDR_W-1:0]     tm_wr_addr;
  logic [DCT_WORD_W-1:0] tm_wr_data;
  logic                  tm_wr_ack;

  // Trace source plus trace memory side.
  modport master (
    output atom_valid, atom_data, tm_wr_ack,
    input  atom_ready, tm_wr_req, tm_wr_addr, tm_wr_data
  );

  // Sequencer side.
  modport slave (
    input  atom_valid, atom_data, tm_wr_ack,
    output atom_ready, tm_wr_req, tm_wr_addr, tm_wr_data
  );

endinterface

// File: rtl/nios2_oci_dct_packer.sv
// Packs trace atoms into a DCT word slot by slot; pads and clears on request.
module nios2_oci_dct_packer
  import nios2_oci_dct_pkg::*;
#(
  parameter logic [DCT_ATOM_W-1:0] PAD_ATOM = 10'h3FF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  accept,
  input  logic                  pad,
  input  logic                  clear,
  input  logic [DCT_ATOM_W-1:0] atom,
  output logic [DCT_WORD_W-1:0] buffer,
  output logic [DCT_CNT_W-1:0]  count
);

  localparam logic [DCT_CNT_W-1:0] CNT_FULL = DCT_CNT_W'(DCT_ATOMS_PER_WORD);

  // Slot register and fill count; clear wins over pad, pad over accept.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      buffer <= '0;
      count  <= '0;
    end else if (clear) begin
      buffer <= '0;
      count  <= '0;
    end else if (pad) begin
      for (int unsigned i = 0; i < DCT_ATOMS_PER_WORD; i++) begin
        if (i >= 32'(count)) buffer[i*DCT_ATOM_W +: DCT_ATOM_W] <= PAD_ATOM;
      end
      count <= CNT_FULL;
    end else if (accept) begin
      buffer[32'(count)*DCT_ATOM_W +: DCT_ATOM_W] <= atom;
      count <= count + DCT_CNT_W'(1);
    end
  end

endmodule

// File: rtl/nios2_oci_dct_ctrl.sv
// DCT trace sequencer: packs atoms, writes words to trace RAM, flushes on end of test.
// Optional build macro DCT_OVERFLOW_STOP_EN: stop capture instead of wrapping the address.
module nios2_oci_dct_ctrl
  import nios2_oci_dct_pkg::*;
#(
  parameter int unsigned           ADDR_W   = 8,
  parameter logic [DCT_ATOM_W-1:0] PAD_ATOM = 10'h3FF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  trace_en,
  input  logic                  test_ending,
  nios2_oci_dct_ctrl_if.slave   bus,
  output logic [DCT_WORD_W-1:0] dct_buffer,
  output logic [3:0]            dct_count,
  output logic                  wrapped,
  output logic                  test_has_ended
);

  localparam logic [ADDR_W-1:0]    ADDR_LAST = '1;
  localparam logic [DCT_CNT_W-1:0] CNT_LAST  = DCT_CNT_W'(DCT_ATOMS_PER_WORD - 1);

  dct_state_e            state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  wr_req_q, wr_req_d;
  logic                  wrapped_q, wrapped_d;
  logic                  ended_q, ended_d;
  logic                  end_pend_q, end_pend_d;
  logic                  flush_q, flush_d;
  logic                  atom_ready_c, accept_c, pad_c, clear_c, ack_c, stop_c;
  logic [DCT_CNT_W-1:0]  cnt;

  nios2_oci_dct_packer #(
    .PAD_ATOM (PAD_ATOM)
  ) u_packer (
    .clk     (clk),
    .reset_n (reset_n),
    .accept  (accept_c),
    .pad     (pad_c),
    .clear   (clear_c),
    .atom    (bus.atom_data),
    .buffer  (dct_buffer),
    .count   (cnt)
  );

  assign ack_c = (state_q == ST_WRITE) && bus.tm_wr_ack;
`ifdef DCT_OVERFLOW_STOP_EN
  assign stop_c = ack_c && (addr_q == ADDR_LAST);
`else
  assign stop_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode; a pending end request pre-empts packing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (end_pend_q) state_d = ST_FLUSH;
                else if (trace_en) state_d = ST_PACK;
      ST_PACK:  if (end_pend_q) state_d = ST_FLUSH;
                else if (accept_c && (cnt == CNT_LAST)) state_d = ST_WRITE;
      ST_WRITE: if (bus.tm_wr_ack) begin
                  if (flush_q || stop_c) state_d = ST_DONE;
                  else if (end_pend_q)   state_d = ST_FLUSH;
                  else                   state_d = ST_PACK;
                end
      ST_FLUSH: state_d = (cnt != '0) ? ST_WRITE : ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode: combinational handshake plus next values of registered outputs.
  always_comb begin
    atom_ready_c = 1'b0;
    atom_ready_c = (state_q == ST_PACK) && trace_en && !end_pend_q;
    accept_c     = atom_ready_c && bus.atom_valid;
    pad_c        = (state_q == ST_FLUSH) && (cnt != '0);
    clear_c      = ack_c;
    wr_req_d     = (state_d == ST_WRITE);
    ended_d      = ended_q || (state_d == ST_DONE);
    wrapped_d    = wrapped_q || (ack_c && (addr_q == ADDR_LAST));
    addr_d       = (ack_c && !stop_c) ? addr_q + ADDR_W'(1) : addr_q;
    end_pend_d   = end_pend_q || (test_ending && (state_q != ST_DONE));
    flush_d      = flush_q || pad_c;
  end

  // Address counter, request and status flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q     <= '0;
      wr_req_q   <= 1'b0;
      wrapped_q  <= 1'b0;
      ended_q    <= 1'b0;
      end_pend_q <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      wr_req_q   <= wr_req_d;
      wrapped_q  <= wrapped_d;
      ended_q    <= ended_d;
      end_pend_q <= end_pend_d;
      flush_q    <= flush_d;
    end
  end

  assign bus.atom_ready = atom_ready_c;
  assign bus.tm_wr_req  = wr_req_q;
  assign bus.tm_wr_addr = addr_q;
  assign bus.tm_wr_data = dct_buffer;
  assign dct_count      = {{(4 - DCT_CNT_W){1'b0}}, cnt};
  assign wrapped        = wrapped_q;
  assign test_has_ended = ended_q;

endmodule

// File: tb/tb_nios2_oci_dct_ctrl.sv
// Directed plus randomized checks of the DCT sequencer against a word-level model.
module tb_nios2_oci_dct_ctrl;

  localparam int unsigned ADDR_W = 2;
  localparam int          DEPTH  = 1 << ADDR_W;
  localparam int          PAD    = 'h3FF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        trace_en;
  logic        test_ending;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        wrapped;
  logic        test_has_ended;

  int vectors     = 0;
  int miscompares = 0;
  int words_done  = 0;

  nios2_oci_dct_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  nios2_oci_dct_ctrl #(.ADDR_W(ADDR_W), .PAD_ATOM(10'h3FF)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .trace_en       (trace_en),
    .test_ending    (test_ending),
    .bus            (bus),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .wrapped        (wrapped),
    .test_has_ended (test_has_ended)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Three atoms to one word by place value: atom k weighs 1024**k.
  function automatic logic [31:0] pack3(input int a0, input int a1, input int a2);
    return 32'(a0 + a1 * 1024 + a2 * 1048576);
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    trace_en       = 1'b0;
    test_ending    = 1'b0;
    bus.atom_valid = 1'b0;
    bus.atom_data  = '0;
    bus.tm_wr_ack  = 1'b0;
    step();
    step();
    reset_n    = 1'b1;
    words_done = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"},   32'(bus.atom_ready), 0);
    check({tag, "_req"},     32'(bus.tm_wr_req), 0);
    check({tag, "_addr"},    32'(bus.tm_wr_addr), 0);
    check({tag, "_buffer"},  32'(dct_buffer), 0);
    check({tag, "_count"},   32'(dct_count), 0);
    check({tag, "_wrapped"}, 32'(wrapped), 0);
    check({tag, "_ended"},   32'(test_has_ended), 0);
  endtask

  // Offer one atom; returns one negedge after it was taken.
  task automatic send_atom(input logic [9:0] d);
    bit ok = 1'b0;
    bus.atom_valid = 1'b1;
    bus.atom_data  = d;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.atom_ready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check("atom_accept", 32'(ok), 1);
    @(posedge clk);
    #1;
    bus.atom_valid = 1'b0;
    step();
  endtask

  // Wait for a write, check it stays stable while ack is withheld, then ack it.
  task automatic service_write(input logic [31:0] exp_data, input int delay);
    bit seen = 1'b0;
    logic [31:0] exp_addr = 32'(words_done % DEPTH);
    for (int i = 0; i < 30; i++) begin
      if (bus.tm_wr_req) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    check("wr_req_seen", 32'(seen), 1);
    check("wr_data", 32'(bus.tm_wr_data), exp_data);
    check("wr_addr", 32'(bus.tm_wr_addr), exp_addr);
    for (int i = 0; i < delay; i++) begin
      step();
      check("hold_req",   32'(bus.tm_wr_req), 1);
      check("hold_data",  32'(bus.tm_wr_data), exp_data);
      check("hold_addr",  32'(bus.tm_wr_addr), exp_addr);
      check("hold_ready", 32'(bus.atom_ready), 0);
    end
    bus.tm_wr_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.tm_wr_ack = 1'b0;
    step();
    check("req_drop", 32'(bus.tm_wr_req), 0);
    words_done++;
  endtask

  // One random word with random source gaps; optionally drop trace_en mid-word.
  task automatic rand_word(input bit pause);
    logic [9:0] a [3];
    for (int k = 0; k < 3; k++) begin
      a[k] = 10'($urandom);
      repeat ($urandom_range(0, 2)) step();
      send_atom(a[k]);
      if (pause && k == 0) begin
        trace_en       = 1'b0;
        bus.atom_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
          #1;
          check("pause_ready", 32'(bus.atom_ready), 0);
          check("pause_count", 32'(dct_count), 1);
          check("pause_req",   32'(bus.tm_wr_req), 0);
          step();
        end
        bus.atom_valid = 1'b0;
        trace_en       = 1'b1;
      end
    end
    check("req_after_third", 32'(bus.tm_wr_req), 1);
    service_write(pack3(int'(a[0]), int'(a[1]), int'(a[2])), $urandom_range(0, 3));
  endtask

  initial begin
    bit saw_req;
    bit saw_end;
    logic [9:0] r [3];

    // Reset state.
    do_reset();
    check_reset_values("rst");

    // First word, ack withheld 5 cycles.
    trace_en = 1'b1;
    send_atom(10'h001);
    send_atom(10'h002);
    send_atom(10'h003);
    check("first_req_timing", 32'(bus.tm_wr_req), 1);
    check("first_data_const", 32'(bus.tm_wr_data), 32'h0030_0801);
    service_write(pack3(1, 2, 3), 5);
    check("first_count_clr", 32'(dct_count), 0);
    check("first_buf_clr",   32'(dct_buffer), 0);
    check("first_addr_next", 32'(bus.tm_wr_addr), 1);

    // Random words up to the last address; one with trace_en dropped mid-word.
    rand_word(1'b1);
    rand_word(1'b0);
    check("pre_wrap_flag", 32'(wrapped), 0);
    rand_word(1'b0);
    check("wrap_flag", 32'(wrapped), 1);
`ifdef DCT_OVERFLOW_STOP_EN
    check("stop_ended", 32'(test_has_ended), 1);
    bus.atom_valid = 1'b1;
    repeat (2) begin
      step();
      check("stop_ready", 32'(bus.atom_ready), 0);
      check("stop_req",   32'(bus.tm_wr_req), 0);
    end
    bus.atom_valid = 1'b0;
`else
    check("wrap_addr",   32'(bus.tm_wr_addr), 0);
    check("wrap_ended",  32'(test_has_ended), 0);
    rand_word(1'b0);
    check("wrap_sticky", 32'(wrapped), 1);
`endif

    // Flush of a partial word.
    do_reset();
    trace_en = 1'b1;
    send_atom(10'h011);
    send_atom(10'h022);
    test_ending = 1'b1;
    step();
    test_ending    = 1'b0;
    bus.atom_valid = 1'b1;
    #1;
    check("end_ready_low", 32'(bus.atom_ready), 0);
    bus.atom_valid = 1'b0;
    service_write(pack3('h011, 'h022, PAD), 2);
    check("flush_ended", 32'(test_has_ended), 1);
    bus.atom_valid = 1'b1;
    repeat (3) begin
      step();
      check("done_ready", 32'(bus.atom_ready), 0);
      check("done_req",   32'(bus.tm_wr_req), 0);
      check("done_ended", 32'(test_has_ended), 1);
    end
    bus.atom_valid = 1'b0;

    // End request while a write waits for its ack.
    do_reset();
    trace_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      r[k] = 10'($urandom);
      send_atom(r[k]);
    end
    test_ending = 1'b1;
    step();
    test_ending = 1'b0;
    service_write(pack3(int'(r[0]), int'(r[1]), int'(r[2])), 2);
    saw_req = 1'b0;
    saw_end = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.tm_wr_req) saw_req = 1'b1;
      if (test_has_ended) saw_end = 1'b1;
      step();
    end
    check("wend_no_flush", 32'(saw_req), 0);
    check("wend_ended",    32'(saw_end), 1);
    check("wend_count",    32'(dct_count), 0);

    // Reset pulse in the middle of a write.
    do_reset();
    trace_en = 1'b1;
    for (int k = 0; k < 3; k++) send_atom(10'($urandom));
    check("mid_req_up", 32'(bus.tm_wr_req), 1);
    reset_n = 1'b0;
    step();
    check_reset_values("mid_rst");
    reset_n = 1'b1;
    saw_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.tm_wr_req) saw_req = 1'b1;
    end
    check("mid_word_lost", 32'(saw_req), 0);
    check("mid_count",     32'(dct_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
